// File: rtl/pi2_inv.sv
// pi2_inv: inverse of the pi2 word permutation (a0 ror 1, a1 kept, a2 rol 10) behind valid/ready.
// Define PI2_INV_FAST_EN to produce the result on the transfer edge instead of rotating a2 serially.
module pi2_inv #(
  parameter int ROT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [95:0] iword,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] oword,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [95:0] r_word;
  logic        w_xfer;
  logic [31:0] w_a0_ror;

  assign w_a0_ror = {iword[0], iword[31:1]};
  assign w_xfer   = in_valid && (r_state == IDLE);
  assign oword    = r_word;

`ifndef PI2_INV_FAST_EN
  localparam int         N        = 10 / ROT_STEP;
  localparam logic [3:0] CNT_LOAD = 4'(N - 1);

  logic [3:0]  r_cnt;
  logic [31:0] w_a2_step;

  assign w_a2_step = {r_word[95-ROT_STEP:64], r_word[95:96-ROT_STEP]};
`else
  logic [31:0] w_a2_rol;

  assign w_a2_rol = {iword[85:64], iword[95:86]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
`ifdef PI2_INV_FAST_EN
        if (in_valid) w_state_next = DONE;
`else
        if (in_valid) w_state_next = ROT;
`endif
      end
      ROT: begin
`ifdef PI2_INV_FAST_EN
        w_state_next = IDLE;
`else
        // the edge that sees the counter at zero performs the final rotation
        if (r_cnt == 4'd0) w_state_next = DONE;
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef PI2_INV_FAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else if (w_xfer) begin
      r_word <= {w_a2_rol, iword[63:32], w_a0_ror};
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (w_xfer) begin
      r_word <= {iword[95:64], iword[63:32], w_a0_ror};
      r_cnt  <= CNT_LOAD;
    end else if (r_state == ROT) begin
      r_word[95:64] <= w_a2_step;
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pi2_inv.sv
// Bench for pi2_inv: two instances (ROT_STEP 1 and 5) checked every cycle against a timestamp model.
// Honors PI2_INV_FAST_EN for the expected latency.
module tb_pi2_inv;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]       iv, ir, ov, ordy, bz;
  logic [1:0][95:0] iw, ow;

  int total = 0;
  int bad   = 0;
  bit chk_en    = 1'b0;
  bit stream_en = 1'b0;
  int tick      = 0;

  bit          m_act  [2];
  int          m_age  [2];
  logic [95:0] m_res  [2];
  int          last_x [2];
  int          xcnt   [2];

  localparam logic [95:0] VEC_IN  = 96'h00000400_12345678_00000001;
  localparam logic [95:0] VEC_OUT = 96'h00100000_12345678_80000000;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      pi2_inv #(.ROT_STEP(gi == 0 ? 1 : 5)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[gi]),
        .in_ready  (ir[gi]),
        .iword     (iw[gi]),
        .out_valid (ov[gi]),
        .out_ready (ordy[gi]),
        .oword     (ow[gi]),
        .busy      (bz[gi])
      );
    end
  endgenerate

  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    logic [63:0] d;
    d = {v, v} << s;
    return d[63:32];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] v, input int s);
    logic [63:0] d;
    d = {v, v} >> s;
    return d[31:0];
  endfunction

  function automatic logic [95:0] inv_model(input logic [95:0] x);
    return {rotl(x[95:64], 10), x[63:32], rotr(x[31:0], 1)};
  endfunction

  function automatic logic [95:0] pi2_fwd(input logic [95:0] x);
    return {rotr(x[95:64], 10), x[63:32], rotl(x[31:0], 1)};
  endfunction

  // edges from the transfer edge until out_valid is first seen high
  function automatic int lat_of(input int k);
`ifdef PI2_INV_FAST_EN
    return 0;
`else
    return (k == 0) ? 10 : 2;
`endif
  endfunction

  task automatic check(input string name, input int k, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Model: a word is in flight from its transfer edge; it is visible once its age reaches the latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 1'b0;
        m_age[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_act[k]) begin
          if (iv[k]) begin
            m_act[k] = 1'b1;
            m_age[k] = 0;
            m_res[k] = inv_model(iw[k]);
          end
        end else if (m_age[k] >= lat_of(k)) begin
          if (ordy[k]) begin
            m_act[k] = 1'b0;
            $display("xfer inst=%0d result=%h", k, m_res[k]);
          end
        end else begin
          m_age[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check("in_ready", k, 96'(ir[k]), 96'(!m_act[k]));
        check("busy", k, 96'(bz[k]), 96'(m_act[k]));
        check("out_valid", k, 96'(ov[k]), 96'(m_act[k] && (m_age[k] >= lat_of(k))));
        if (m_act[k] && (m_age[k] >= lat_of(k))) check("oword", k, ow[k], m_res[k]);
      end
    end
  end

  always @(posedge clk) begin
    tick++;
    for (int k = 0; k < 2; k++) begin
      if (stream_en && iv[k] && ir[k]) begin
        if (last_x[k] >= 0) check("spacing", k, 96'(tick - last_x[k]), 96'(lat_of(k) + 2));
        last_x[k] = tick;
        xcnt[k]++;
      end
    end
  end

  task automatic run_vec(input logic [95:0] x);
    logic [1:0]       seen;
    logic [1:0][95:0] got;
    seen = 2'b00;
    got  = '0;
    @(negedge clk);
    iw[0] = pi2_fwd(x);
    iw[1] = pi2_fwd(x);
    iv    = 2'b11;
    ordy  = 2'b11;
    @(negedge clk);
    iv = 2'b00;
    for (int c = 0; c < 30 && seen != 2'b11; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (ov[k] && !seen[k]) begin
          seen[k] = 1'b1;
          got[k]  = ow[k];
        end
      end
      if (seen != 2'b11) @(negedge clk);
    end
    for (int k = 0; k < 2; k++) check("vec", k, seen[k] ? got[k] : 96'bx, x);
  endtask

  initial begin
    int first [2];
    iv   = 2'b00;
    ordy = 2'b00;
    iw   = '0;
    for (int k = 0; k < 2; k++) begin
      last_x[k] = -1;
      xcnt[k]   = 0;
    end

    check("model_pin", 0, inv_model(VEC_IN), VEC_OUT);
    check("model_pin_fwd", 0, pi2_fwd(VEC_OUT), VEC_IN);

    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", k, 96'(ir[k]), 96'd1);
      check("rst_out_valid", k, 96'(ov[k]), 96'd0);
      check("rst_busy", k, 96'(bz[k]), 96'd0);
      check("rst_oword", k, ow[k], 96'd0);
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // literal vector, first-valid latency, then hold with out_ready low
    @(negedge clk);
    iw[0] = VEC_IN;
    iw[1] = VEC_IN;
    iv    = 2'b11;
    @(negedge clk);
    iv = 2'b00;
    first[0] = -1;
    first[1] = -1;
    for (int c = 0; c <= 30; c++) begin
      for (int k = 0; k < 2; k++) if (ov[k] && first[k] < 0) first[k] = c;
      if (first[0] >= 0 && first[1] >= 0) break;
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      check("latency", k, 96'(first[k]), 96'(lat_of(k)));
      check("vec_literal", k, ow[k], VEC_OUT);
    end
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("hold_valid", k, 96'(ov[k]), 96'd1);
        check("hold_oword", k, ow[k], VEC_OUT);
        check("hold_in_ready", k, 96'(ir[k]), 96'd0);
      end
    end
    ordy = 2'b11;
    @(negedge clk);
    ordy = 2'b00;
    for (int k = 0; k < 2; k++) begin
      check("release_in_ready", k, 96'(ir[k]), 96'd1);
      check("release_valid", k, 96'(ov[k]), 96'd0);
      check("release_busy", k, 96'(bz[k]), 96'd0);
    end

    // asynchronous reset with the serial instance's counter at 4
    @(negedge clk);
    iw[0] = 96'hDEADBEEF_CAFEF00D_01234567;
    iw[1] = 96'hDEADBEEF_CAFEF00D_01234567;
    iv    = 2'b11;
    @(negedge clk);
    iv = 2'b00;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("arst_out_valid", k, 96'(ov[k]), 96'd0);
      check("arst_busy", k, 96'(bz[k]), 96'd0);
      check("arst_in_ready", k, 96'(ir[k]), 96'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(96'h13579BDF_2468ACE0_FEDCBA98);

    for (int i = 0; i < 100; i++) run_vec({$urandom, $urandom, $urandom});

    // streaming: in_valid held high with out_ready high
    @(negedge clk);
    ordy      = 2'b11;
    iv        = 2'b11;
    stream_en = 1'b1;
    repeat (60) begin
      @(negedge clk);
      iw[0] = {$urandom, $urandom, $urandom};
      iw[1] = {$urandom, $urandom, $urandom};
    end
    stream_en = 1'b0;
    iv        = 2'b00;
    for (int k = 0; k < 2; k++) check("xfer_count", k, 96'(xcnt[k]), 96'(59 / (lat_of(k) + 2) + 1));

    // random handshake traffic
    repeat (400) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        ordy[k] = ($urandom_range(0, 3) != 0);
        iw[k]   = {$urandom, $urandom, $urandom};
      end
    end
    iv   = 2'b00;
    ordy = 2'b11;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
